// File: rtl/neuron_layer_mac_if.sv
// neuron_layer_mac_if
// Bus between the layer engine and its shared resources: the external
// weight RAM and the pool of LANES signed fixed-point multipliers.
//
// Handshake semantics (no ready signals on this bus):
//   - ram_rd qualifies ram_addr. The RAM always accepts the read, and the
//     word appears on ram_values exactly one cycle later.
//   - The multipliers are combinational. mult_res[l] follows mult_v1[l] and
//     mult_v2[l] in the same cycle. The result is already rescaled to the
//     operand format and saturated.
//
// Signals:
//   ram_rd      engine -> RAM   read strobe
//   ram_addr    engine -> RAM   weight word address
//   ram_values  RAM -> engine   LANES weights of the addressed word
//   mult_v1     engine -> mult  operand 1 (weight) per lane
//   mult_v2     engine -> mult  operand 2 (layer operand) per lane
//   mult_res    mult -> engine  product per lane
//
// Modports:
//   master  the layer engine
//   slave   the RAM / multiplier side
interface neuron_layer_mac_if #(
    parameter int NUM_W      = 16,
    parameter int LANES      = 2,
    parameter int RAM_ADDR_W = 8
);
    logic                  ram_rd;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [NUM_W-1:0]      ram_values [0:LANES-1];
    logic [NUM_W-1:0]      mult_v1    [0:LANES-1];
    logic [NUM_W-1:0]      mult_v2    [0:LANES-1];
    logic [NUM_W-1:0]      mult_res   [0:LANES-1];

    modport master (
        output ram_rd, ram_addr, mult_v1, mult_v2,
        input  ram_values, mult_res
    );

    modport slave (
        input  ram_rd, ram_addr, mult_v1, mult_v2,
        output ram_values, mult_res
    );
endinterface

// File: rtl/neuron_layer_mac.sv
// neuron_layer_mac
// Time-multiplexed fully-connected layer engine. It runs one of two passes:
//   forward:  res_f[o] = sum_i W[o][i] * fwd_in[i]
//   backward: res_b[i] = sum_o W[o][i] * bwd_in[o]
// Each cycle it fetches one RAM word of LANES weights, and it uses LANES
// shared multipliers.
//
// Ports:
//   clk, nreset  clock; asynchronous active-low reset
//   start        request a pass (sampled only in IDLE)
//   mode         0 = forward, 1 = backward (captured with start)
//   fwd_in       forward operands (captured with start)
//   bwd_in       backward operands (captured with start)
//   busy         high while a pass is in progress
//   done         one-cycle pulse in the DONE state
//   res_f, res_b saturated results of the last forward / backward pass
//   state_dbg    current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   bus          weight RAM and multiplier bus (master side)
module neuron_layer_mac #(
    parameter int INT_W      = 8,
    parameter int FRAC_W     = 8,
    parameter int NUM_W      = INT_W + FRAC_W,
    parameter int INPUTS     = 4,
    parameter int OUTPUTS    = 2,
    parameter int LANES      = 2,
    parameter int RAM_ADDR_W = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic             mode,
    input  logic [NUM_W-1:0] fwd_in [0:INPUTS-1],
    input  logic [NUM_W-1:0] bwd_in [0:OUTPUTS-1],
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] res_f  [0:OUTPUTS-1],
    output logic [NUM_W-1:0] res_b  [0:INPUTS-1],
    output logic [1:0]       state_dbg,
    neuron_layer_mac_if.master bus
);
    localparam int WORDS  = OUTPUTS * INPUTS / LANES;
    localparam int MAX_IO = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS;
    localparam int ACC_W  = NUM_W + $clog2(MAX_IO) + 1;
    localparam int COL_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int ROW_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic                    mode_r;
    logic [NUM_W-1:0]        fwd_r [0:INPUTS-1];
    logic [NUM_W-1:0]        bwd_r [0:OUTPUTS-1];
    logic signed [ACC_W-1:0] acc_f [0:OUTPUTS-1];
    logic signed [ACC_W-1:0] acc_b [0:INPUTS-1];

    // The iss_* counters give the row and column base of the word now on
    // ram_addr. The cons_* registers are the same values one cycle later,
    // aligned with the returning RAM data.
    logic [ROW_W-1:0]        iss_row, cons_row;
    logic [COL_W-1:0]        iss_col, cons_col;
    logic                    cons_vld;

    logic signed [ACC_W-1:0] prod_ext [0:LANES-1];
    logic signed [ACC_W-1:0] lane_sum;

    assign state_dbg = state;

    // Clamp an accumulator to the representable range of the number format.
    function automatic logic [NUM_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-NUM_W:0] top;
        top = a[ACC_W-1:NUM_W-1];
        if ((&top) || (~|top))
            return a[NUM_W-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(NUM_W-1){1'b0}}};
        else
            return {1'b0, {(NUM_W-1){1'b1}}};
    endfunction

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod_ext[l] = {{(ACC_W-NUM_W){bus.mult_res[l][NUM_W-1]}}, bus.mult_res[l]};
            lane_sum    = lane_sum + prod_ext[l];
        end
    end

    // The multiplier operands are driven only while a RAM word is being
    // consumed. At all other times they are held at zero.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            bus.mult_v1[l] = '0;
            bus.mult_v2[l] = '0;
            if (cons_vld) begin
                bus.mult_v1[l] = bus.ram_values[l];
                bus.mult_v2[l] = mode_r ? bwd_r[cons_row] : fwd_r[cons_col + COL_W'(l)];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mode_r       <= 1'b0;
            bus.ram_rd   <= 1'b0;
            bus.ram_addr <= '0;
            iss_row      <= '0;
            iss_col      <= '0;
            cons_row     <= '0;
            cons_col     <= '0;
            cons_vld     <= 1'b0;
            for (int i = 0; i < INPUTS; i++) begin
                fwd_r[i] <= '0;
                acc_b[i] <= '0;
                res_b[i] <= '0;
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                bwd_r[o] <= '0;
                acc_f[o] <= '0;
                res_f[o] <= '0;
            end
        end else begin
            cons_vld <= bus.ram_rd;
            cons_row <= iss_row;
            cons_col <= iss_col;

            if (cons_vld) begin
                if (!mode_r) begin
                    acc_f[cons_row] <= acc_f[cons_row] + lane_sum;
                end else begin
                    for (int l = 0; l < LANES; l++)
                        acc_b[cons_col + COL_W'(l)] <= acc_b[cons_col + COL_W'(l)] + prod_ext[l];
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        mode_r       <= mode;
                        bus.ram_rd   <= 1'b1;
                        bus.ram_addr <= '0;
                        iss_row      <= '0;
                        iss_col      <= '0;
                        for (int i = 0; i < INPUTS; i++) begin
                            fwd_r[i] <= fwd_in[i];
                            acc_b[i] <= '0;
                        end
                        for (int o = 0; o < OUTPUTS; o++) begin
                            bwd_r[o] <= bwd_in[o];
                            acc_f[o] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.ram_addr == RAM_ADDR_W'(WORDS - 1)) begin
                        bus.ram_rd   <= 1'b0;
                        bus.ram_addr <= '0;
                        state        <= S_DRAIN;
                    end else begin
                        bus.ram_addr <= bus.ram_addr + RAM_ADDR_W'(1);
                        // A word never straddles two rows, so the column
                        // base wraps exactly at the end of a row.
                        if (iss_col == COL_W'(INPUTS - LANES)) begin
                            iss_col <= '0;
                            iss_row <= iss_row + ROW_W'(1);
                        end else begin
                            iss_col <= iss_col + COL_W'(LANES);
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    if (!mode_r) begin
                        for (int o = 0; o < OUTPUTS; o++)
                            res_f[o] <= sat(acc_f[o]);
                    end else begin
                        for (int i = 0; i < INPUTS; i++)
                            res_b[i] <= sat(acc_b[i]);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_layer_mac.sv
// tb_neuron_layer_mac
// Directed bench for neuron_layer_mac with INPUTS=4, OUTPUTS=2, LANES=2, so
// the layer has 4 weight words. The bench models the weight RAM with one
// cycle of read latency. It models each multiplier as sat((v1*v2)>>>8).
module tb_neuron_layer_mac;
    localparam int NW = 16;

    logic          clk;
    logic          nreset;
    logic          start;
    logic          mode;
    logic [NW-1:0] fwd_in [0:3];
    logic [NW-1:0] bwd_in [0:1];
    logic          busy;
    logic          done;
    logic [NW-1:0] res_f  [0:1];
    logic [NW-1:0] res_b  [0:3];
    logic [1:0]    state_dbg;

    neuron_layer_mac_if #(.NUM_W(16), .LANES(2), .RAM_ADDR_W(8)) bus ();

    neuron_layer_mac #(
        .INT_W(8), .FRAC_W(8), .INPUTS(4), .OUTPUTS(2), .LANES(2), .RAM_ADDR_W(8)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .mode(mode),
        .fwd_in(fwd_in), .bwd_in(bwd_in), .busy(busy), .done(done),
        .res_f(res_f), .res_b(res_b), .state_dbg(state_dbg), .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM and multiplier models ----------------
    logic [NW-1:0] w_mem [0:7];

    always @(posedge clk) begin
        if (bus.ram_rd)
            for (int l = 0; l < 2; l++)
                bus.ram_values[l] <= w_mem[int'(bus.ram_addr) * 2 + l];
    end

    function automatic logic [NW-1:0] mul_sat(input logic [NW-1:0] a, input logic [NW-1:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> 8;
        if (p > 32767) return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    always_comb begin
        for (int l = 0; l < 2; l++)
            bus.mult_res[l] = mul_sat(bus.mult_v1[l], bus.mult_v2[l]);
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic               mode;
        logic [7:0][NW-1:0] w;      // w[k], k = o*4 + i
        logic [3:0][NW-1:0] fwd;
        logic [1:0][NW-1:0] bwd;
        logic [1:0][NW-1:0] exp_f;
        logic [3:0][NW-1:0] exp_b;
    } vec_t;

    vec_t vecs [0:6];

    function automatic logic [7:0][NW-1:0] w8(input logic [NW-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][NW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    function automatic logic [7:0][NW-1:0] rowu(input logic [NW-1:0] r0, input logic [NW-1:0] r1);
        return w8(r0, r0, r0, r0, r1, r1, r1, r1);
    endfunction

    function automatic logic [3:0][NW-1:0] q4(input logic [NW-1:0] a0, a1, a2, a3);
        logic [3:0][NW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    function automatic logic [1:0][NW-1:0] q2(input logic [NW-1:0] a0, a1);
        logic [1:0][NW-1:0] r;
        r[0] = a0; r[1] = a1;
        return r;
    endfunction

    task automatic load_inputs(input vec_t v);
        for (int k = 0; k < 8; k++) w_mem[k] = v.w[k];
        mode = v.mode;
        for (int i = 0; i < 4; i++) fwd_in[i] = v.fwd[i];
        for (int o = 0; o < 2; o++) bwd_in[o] = v.bwd[o];
    endtask

    task automatic scramble_inputs();
        mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) fwd_in[i] = 16'($urandom_range(0, 65535));
        for (int o = 0; o < 2; o++) bwd_in[o] = 16'($urandom_range(0, 65535));
    endtask

    // One full pass, called at a negedge while the DUT is idle. The first
    // posedge after the call is the start edge E0.
    task automatic run_pass(input int id, input vec_t v);
        load_inputs(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            chk($sformatf("v%0d rd/addr c%0d", id, a), {23'd0, bus.ram_rd, bus.ram_addr}, {23'd0, 1'b1, 8'(a)});
            chk($sformatf("v%0d busy c%0d", id, a), {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk($sformatf("v%0d drain rd/done/state", id), {29'd0, bus.ram_rd, done, state_dbg}, {29'd0, 1'b0, 1'b0, 2'd2});
        @(negedge clk);
        chk($sformatf("v%0d done busy/done/state", id), {29'd0, busy, done, state_dbg}, {29'd0, 1'b1, 1'b1, 2'd3});
        @(negedge clk);
        chk($sformatf("v%0d idle busy/done/state", id), {29'd0, busy, done, state_dbg}, 32'd0);
        for (int o = 0; o < 2; o++)
            chk($sformatf("v%0d res_f[%0d]", id, o), {16'd0, res_f[o]}, {16'd0, v.exp_f[o]});
        for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d res_b[%0d]", id, i), {16'd0, res_b[i]}, {16'd0, v.exp_b[i]});
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] exp_q [$];
    int         done_cnt;
    logic [7:0] got;

    initial begin
        // Forward, uniform weights: 1+2+3+4 = 10.0.
        vecs[0] = '{mode: 1'b0, w: rowu(16'h0100, 16'h0100),
                    fwd: q4(16'h0100, 16'h0200, 16'h0300, 16'h0400), bwd: q2(16'h0000, 16'h0000),
                    exp_f: q2(16'h0A00, 16'h0A00), exp_b: q4(16'h0000, 16'h0000, 16'h0000, 16'h0000)};
        // Backward: 1.0*2.0 + (-1.0)*0.5 = 1.5 for every input.
        vecs[1] = '{mode: 1'b1, w: rowu(16'h0100, 16'hFF00),
                    fwd: q4(16'h0000, 16'h0000, 16'h0000, 16'h0000), bwd: q2(16'h0200, 16'h0080),
                    exp_f: q2(16'h0A00, 16'h0A00), exp_b: q4(16'h0180, 16'h0180, 16'h0180, 16'h0180)};
        // Forward positive saturation: 4*100.0.
        vecs[2] = '{mode: 1'b0, w: rowu(16'h6400, 16'h6400),
                    fwd: q4(16'h0100, 16'h0100, 16'h0100, 16'h0100), bwd: q2(16'h0000, 16'h0000),
                    exp_f: q2(16'h7FFF, 16'h7FFF), exp_b: q4(16'h0180, 16'h0180, 16'h0180, 16'h0180)};
        // Forward negative saturation: 4*(-100.0).
        vecs[3] = '{mode: 1'b0, w: rowu(16'h9C00, 16'h9C00),
                    fwd: q4(16'h0100, 16'h0100, 16'h0100, 16'h0100), bwd: q2(16'h0000, 16'h0000),
                    exp_f: q2(16'h8000, 16'h8000), exp_b: q4(16'h0180, 16'h0180, 16'h0180, 16'h0180)};
        // Forward with distinct weights. W0 = {1,2,3,4}, W1 = {-1,0,0,1},
        // x = {1,-1,2,0.25}. Row 0 = 6.0, row 1 = -0.75.
        vecs[4] = '{mode: 1'b0,
                    w: w8(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFF00, 16'h0000, 16'h0000, 16'h0100),
                    fwd: q4(16'h0100, 16'hFF00, 16'h0200, 16'h0040), bwd: q2(16'h0000, 16'h0000),
                    exp_f: q2(16'h0600, 16'hFF40), exp_b: q4(16'h0180, 16'h0180, 16'h0180, 16'h0180)};
        // Backward with the same weights and y = {1,2}. Results are
        // {1-2, 2+0, 3+0, 4+2} = {-1, 2, 3, 6}.
        vecs[5] = '{mode: 1'b1,
                    w: w8(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFF00, 16'h0000, 16'h0000, 16'h0100),
                    fwd: q4(16'h0000, 16'h0000, 16'h0000, 16'h0000), bwd: q2(16'h0100, 16'h0200),
                    exp_f: q2(16'h0600, 16'hFF40), exp_b: q4(16'hFF00, 16'h0200, 16'h0300, 16'h0600)};
        // Backward positive saturation: 100.0 + 100.0.
        vecs[6] = '{mode: 1'b1, w: rowu(16'h6400, 16'h6400),
                    fwd: q4(16'h0000, 16'h0000, 16'h0000, 16'h0000), bwd: q2(16'h0100, 16'h0100),
                    exp_f: q2(16'h0600, 16'hFF40), exp_b: q4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF)};

        // Reset, then stay idle.
        nreset = 1'b0;
        start  = 1'b0;
        for (int k = 0; k < 8; k++) w_mem[k] = '0;
        load_inputs(vecs[0]);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk($sformatf("idle c%0d busy/done/rd/state", n), {28'd0, busy, done, bus.ram_rd, 1'b0, state_dbg}, 32'd0);
            chk($sformatf("idle c%0d addr", n), {24'd0, bus.ram_addr}, 32'd0);
        end
        chk("idle mult_v", {bus.mult_v1[0], bus.mult_v2[1]}, 32'd0);
        for (int o = 0; o < 2; o++) chk($sformatf("reset res_f[%0d]", o), {16'd0, res_f[o]}, 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("reset res_b[%0d]", i), {16'd0, res_b[i]}, 32'd0);

        // Table-driven passes.
        for (int v = 0; v < 7; v++) run_pass(v, vecs[v]);

        // Back-to-back passes with start held high. start is dropped for one
        // mid-pass cycle; because the FSM is not in IDLE, that has no effect.
        load_inputs(vecs[0]);
        exp_q = {8'd5, 8'd12, 8'd19};
        start = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) start = 1'b0;
            if (n == 3) start = 1'b1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("b2b unexpected done", {24'd0, 8'(n)}, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    chk("b2b done cycle", {24'd0, 8'(n)}, {24'd0, got});
                end
            end
            if (n == 6 || n == 13 || n == 20)
                chk($sformatf("b2b res_f c%0d", n), {res_f[0], res_f[1]}, 32'h0A00_0A00);
        end
        start = 1'b0;
        chk("b2b passes left", exp_q.size(), 32'd0);

        // Single pass with extra start pulses in RUN and in DONE. The pulses
        // are ignored, and changing the operands mid-pass has no effect.
        load_inputs(vecs[0]);
        start    = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            start = (n == 2 || n == 5);
            if (n == 1) scramble_inputs();
            if (done) done_cnt++;
            if (n == 5) chk("pulse done in c5", {31'd0, done}, 32'd1);
        end
        chk("pulse done count", done_cnt, 32'd1);
        chk("pulse res_f", {res_f[0], res_f[1]}, 32'h0A00_0A00);

        // Reset in the middle of a pass.
        load_inputs(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("arst busy/done/rd/state", {28'd0, busy, done, bus.ram_rd, 1'b0, state_dbg}, 32'd0);
        chk("arst addr", {24'd0, bus.ram_addr}, 32'd0);
        chk("arst res_f", {res_f[0], res_f[1]}, 32'd0);
        chk("arst res_b", {res_b[0], res_b[1], res_b[2], res_b[3]} == 64'd0, 32'd1);
        chk("arst mult_v", {bus.mult_v1[0], bus.mult_v2[0]}, 32'd0);
        repeat (2) @(negedge clk);
        nreset   = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("arst no done", done_cnt, 32'd0);
        run_pass(7, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
